// File: rtl/x_serializer_pkg.sv
// Shared definitions for the x serializer and the benches that decode its state.
package x_serializer_pkg;

  // Two-state control: waiting for a word, or shifting one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Level driven on x whenever no word is being shifted.
  localparam logic IDLE_X_DEFAULT = 1'b0;

  // Bit-counter width: clog2(width), never narrower than one bit.
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/x_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word over valid/ready and
// shifts it out one bit per enabled clock on a registered x, with x_valid and
// last marking the real stimulus cycles. Back-to-back words stream bubble-free.
module x_serializer
  import x_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter logic IDLE_X    = IDLE_X_DEFAULT,
  parameter bit   MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             advance,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int            CW         = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_count, w_count_nxt, w_count_inc;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
  logic             r_x, w_x_nxt;
  logic             r_x_valid, w_x_valid_nxt;
  logic             r_last, w_last_nxt;
  logic             w_on_final;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;

  // The final bit is being consumed this cycle; a new word may slot in here.
  assign w_on_final  = (r_state == SHIFT) && advance && (r_count == LAST_COUNT);
  assign load_ready  = !reset && ((r_state == IDLE) || w_on_final);
  assign w_accept    = load_valid && load_ready;
  assign w_count_inc = r_count + CW'(1);

  // Bit order is fixed per instance. The register rotates rather than shifting
  // in zeros so that every stored bit stays live; the wrapped-around bit is
  // never presented because the counter ends the word first.
  if (MSB_FIRST) begin : g_msb_first
    assign w_first_bit = data_in[WIDTH-1];
    assign w_shifted   = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
    assign w_next_bit  = w_shifted[WIDTH-1];
  end else begin : g_lsb_first
    assign w_first_bit = data_in[0];
    assign w_shifted   = {r_shift[0], r_shift[WIDTH-1:1]};
    assign w_next_bit  = w_shifted[0];
  end

  // Next-state and next-output logic for the IDLE/SHIFT controller.
  always_comb begin
    // NOTE: every target gets a hold value first so no path leaves one
    // unassigned; a missing default here would infer a latch.
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_shift_nxt   = r_shift;
    w_x_nxt       = r_x;
    w_x_valid_nxt = r_x_valid;
    w_last_nxt    = r_last;

    if (w_accept) begin
      // New word: first bit appears on x one cycle after acceptance.
      w_state_nxt   = SHIFT;
      w_count_nxt   = '0;
      w_shift_nxt   = data_in;
      w_x_nxt       = w_first_bit;
      w_x_valid_nxt = 1'b1;
      w_last_nxt    = 1'b0;
    end else if ((r_state == SHIFT) && advance) begin
      if (r_count == LAST_COUNT) begin
        // Final bit consumed with nothing queued behind it.
        w_state_nxt   = IDLE;
        w_count_nxt   = '0;
        w_x_nxt       = IDLE_X;
        w_x_valid_nxt = 1'b0;
        w_last_nxt    = 1'b0;
      end else begin
        w_count_nxt   = w_count_inc;
        w_shift_nxt   = w_shifted;
        w_x_nxt       = w_next_bit;
        w_x_valid_nxt = 1'b1;
        w_last_nxt    = (w_count_inc == LAST_COUNT);
      end
    end
    // SHIFT with advance low: everything holds via the defaults (stall).
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_shift   <= '0;
      r_x       <= IDLE_X;
      r_x_valid <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_shift   <= w_shift_nxt;
      r_x       <= w_x_nxt;
      r_x_valid <= w_x_valid_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign x       = r_x;
  assign x_valid = r_x_valid;
  assign last    = r_last;
  assign busy    = (r_state == SHIFT);

endmodule

// File: doc/x_serializer.md
Name: x_serializer

Overview:
Parallel-to-serial front end that produces the single-bit input stream `x` for the two-state-bit sequence FSM that runs on the same `clk`. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock. It also supplies `x_valid` and `last` so the downstream FSM and its checker know which cycles carry real stimulus. Back-to-back words stream without a bubble.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
IDLE_X, 0, value driven on `x` when no word is being shifted.
MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

Ports:
clk  in  1  single system clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
data_in  in  WIDTH  word to serialize; sampled only on an accepted load.
load_valid  in  1  producer offers `data_in`.
load_ready  out  1  serializer can accept a word this cycle (combinational).
advance  in  1  shift enable from the consumer; when low, all serializer state holds.
x  out  1  serial bit to the FSM (registered).
x_valid  out  1  `x` carries a data bit (registered).
last  out  1  `x` carries the final bit of the current word (registered).
busy  out  1  a word is in flight; equals state==SHIFT.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is synchronous and active-high.
- Reset values: state=IDLE, count=0, shift register=0, x=IDLE_X, x_valid=0, last=0, busy=0.
- `load_ready` is forced to 0 during any cycle in which reset is high.
- States: IDLE and SHIFT. The bit counter is clog2(WIDTH) bits wide.
- `load_ready` = !reset && (IDLE || (SHIFT && advance && count==WIDTH-1)).
- Accept = load_valid && load_ready. On accept:
  - the shift register captures `data_in`, count=0, state becomes SHIFT;
  - on the next cycle x = first bit, x_valid=1, last=0;
  - latency is one cycle from accept to first bit.
- In SHIFT with advance=1 and count<WIDTH-1:
  - shift by one toward the output end and count++;
  - `x` shows the next bit; `last` is 1 exactly when the new count equals WIDTH-1.
- In SHIFT with advance=0: count, shift register, x, x_valid and last all hold. This is a stall; no bit is skipped or repeated beyond the hold.
- In SHIFT with advance=1 and count==WIDTH-1, the final bit has been consumed:
  - if load_valid=1, the new word is accepted in the same cycle with no bubble; the next cycle shows the new word's first bit with x_valid=1;
  - otherwise state becomes IDLE, and next cycle x=IDLE_X, x_valid=0, last=0.
- `load_valid` while SHIFT and not on the final bit: ignored. `data_in` is not sampled and the current word is unaffected.
- `load_valid` in IDLE is accepted regardless of `advance`. `advance` gates shifting only.
- Reset asserted mid-word: the word is abandoned and all outputs take reset values on the next edge. The partial word is never resumed.
- Bit order is fixed per instance by MSB_FIRST; no run-time change.
- Each word produces exactly WIDTH cycles with x_valid=1 and advance=1, and exactly one `last` pulse per word (held through stalls).

Decomposition:
- Shared package:
  - the state enum {IDLE, SHIFT};
  - a count-width constant/function clog2(WIDTH);
  - IDLE_X default.
  The FSM checker bench imports this package to decode `busy`/state in waveforms.
- No sub-module; the shift register, counter and 2-state FSM form one block of roughly 150 lines.

Test Plan:
- Basic shift: WIDTH=8, MSB_FIRST=1, advance=1; load 8'b1011_0010 at cycle 0 -> x = 1,0,1,1,0,0,1,0 on cycles 1..8, x_valid=1 on 1..8, last=1 only on cycle 8; cycle 9 has x=0, x_valid=0, busy=0.
- Back-to-back: load 8'hA5, then hold load_valid=1 with 8'h3C -> second accept at cycle 8; x shows 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0 with no x_valid gap.
- Stall: load 8'hF0, drop advance on cycles 3-5 -> x holds its cycle-3 value (1) through cycle 5; word finishes at cycle 11 with last=1 held during any stall on the final bit.
- Load ignored while busy: pulse load_valid with 8'hFF at cycles 2-4 of word 8'h00 -> load_ready=0 there, x stays 0 for all 8 bits, no second word follows.
- Reset mid-word: assert reset at cycle 4 of word 8'hAA -> cycle 5 has x=IDLE_X, x_valid=0, busy=0; load_ready=1 in cycle 5; a new load 8'h81 then shifts 1,0,0,0,0,0,0,1 cleanly.
- LSB-first: MSB_FIRST=0, load 8'b0000_0110 -> x = 0,1,1,0,0,0,0,0.
